// File: rtl/mult_datapath.sv
// mult_datapath: sign-magnitude shift-add datapath for an 8x8 signed multiply.
// Operands are converted to magnitudes on load and the sign is kept separately.
// The product register accumulates the unsigned partial products, one
// multiplier bit per shift cycle. The signed result is formed combinationally.
// A control unit outside this block sequences load, shift_en, psel and reg_en.
module mult_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        reg_en,
  input  logic        shift_en,
  input  logic        psel,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [15:0] product,
  output logic        z_flag_multiplier,
  output logic [3:0]  iter_cnt
);

  logic [15:0] mcand_reg;
  logic [7:0]  mplier_reg;
  logic [15:0] prod_reg;
  logic        sign_reg;

  logic [7:0]  mag_a;
  logic [7:0]  mag_b;
  logic [15:0] prod_sum;
  logic [15:0] prod_next;
  logic [3:0]  iter_next;

  // Operand magnitudes in 8-bit unsigned; -128 maps to 0x80 without overflow.
  always_comb begin
    mag_a = multiplicand[7] ? (~multiplicand + 8'd1) : multiplicand;
    mag_b = multiplier[7]   ? (~multiplier + 8'd1)   : multiplier;
  end

  // Next product for a shift cycle: psel=0 clears, an LSB of 1 adds the
  // shifted multiplicand, otherwise hold. Max magnitude 16384 fits in 16 bits.
  always_comb begin
    prod_sum = prod_reg + mcand_reg;
    if (!psel)
      prod_next = 16'd0;
    else if (mplier_reg[0])
      prod_next = prod_sum;
    else
      prod_next = prod_reg;
  end

  // Iteration counter increment, saturating at 15.
  always_comb begin
    iter_next = (iter_cnt == 4'hF) ? iter_cnt : (iter_cnt + 4'd1);
  end

  // Register update. load wins over shift_en, and reg_en gates everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= 16'd0;
      mplier_reg <= 8'd0;
      prod_reg   <= 16'd0;
      sign_reg   <= 1'b0;
      iter_cnt   <= 4'd0;
    end else if (reg_en) begin
      if (load) begin
        mcand_reg  <= {8'd0, mag_a};
        mplier_reg <= mag_b;
        prod_reg   <= 16'd0;
        sign_reg   <= multiplicand[7] ^ multiplier[7];
        iter_cnt   <= 4'd0;
      end else if (shift_en) begin
        mcand_reg  <= {mcand_reg[14:0], 1'b0};
        mplier_reg <= {1'b0, mplier_reg[7:1]};
        prod_reg   <= prod_next;
        iter_cnt   <= iter_next;
      end
    end
  end

  // Signed result from the stored sign and magnitude. A zero magnitude negates
  // to zero, so a negative sign never produces a nonzero result here.
  always_comb begin
    product           = sign_reg ? (~prod_reg + 16'd1) : prod_reg;
    z_flag_multiplier = (mplier_reg == 8'd0);
  end

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: directed operand pairs, a product model computed from
// the original signed operands, per-cycle comparison, and literal spot checks.
module tb_mult_datapath;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        reg_en;
  logic        shift_en;
  logic        psel;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic        z_flag_multiplier;
  logic [3:0]  iter_cnt;

  int vec_cnt;
  int err_cnt;
  bit chk_on;

  // Model: operand magnitudes, sign, shifts since load, accumulated magnitude.
  int a_mag;
  int b_mag;
  int n_sh;
  int acc;
  bit sgn;

  mult_datapath dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load              (load),
    .reg_en            (reg_en),
    .shift_en          (shift_en),
    .psel              (psel),
    .multiplicand      (multiplicand),
    .multiplier        (multiplier),
    .product           (product),
    .z_flag_multiplier (z_flag_multiplier),
    .iter_cnt          (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int abs8(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [15:0] exp_product();
    int v;
    v = sgn ? -acc : acc;
    return v[15:0];
  endfunction

  function automatic logic exp_z();
    return ((b_mag >> n_sh) == 0);
  endfunction

  function automatic logic [3:0] exp_iter();
    int v;
    v = (n_sh > 15) ? 15 : n_sh;
    return v[3:0];
  endfunction

  // Multiplication as a sum of partial products: shift i contributes
  // |A|*2^i when bit i of |B| is set; a psel=0 shift restarts the sum.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag <= 0;
      b_mag <= 0;
      n_sh  <= 0;
      acc   <= 0;
      sgn   <= 1'b0;
    end else if (reg_en && load) begin
      a_mag <= abs8(multiplicand);
      b_mag <= abs8(multiplier);
      n_sh  <= 0;
      acc   <= 0;
      sgn   <= multiplicand[7] ^ multiplier[7];
    end else if (reg_en && shift_en) begin
      if (!psel)
        acc <= 0;
      else if (((b_mag >> n_sh) & 1) == 1)
        acc <= acc + (a_mag << n_sh);
      n_sh <= n_sh + 1;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      vec_cnt++;
      if (product !== exp_product()) begin
        err_cnt++;
        $display("FAIL model_product t=%0t got=%h want=%h", $time, product, exp_product());
      end
      vec_cnt++;
      if (z_flag_multiplier !== exp_z()) begin
        err_cnt++;
        $display("FAIL model_zflag t=%0t got=%b want=%b", $time, z_flag_multiplier, exp_z());
      end
      vec_cnt++;
      if (iter_cnt !== exp_iter()) begin
        err_cnt++;
        $display("FAIL model_iter t=%0t got=%0d want=%0d", $time, iter_cnt, exp_iter());
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic l, input logic s, input logic p,
                     input logic [7:0] a, input logic [7:0] b);
    reg_en       = e;
    load         = l;
    shift_en     = s;
    psel         = p;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] b);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, a, b);
  endtask

  // Shift cycles with junk on the operand inputs; they must be ignored.
  task automatic do_shift(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    chk_on  = 1'b0;
    rst_n   = 1'b1;
    reg_en = 1'b0; load = 1'b0; shift_en = 1'b0; psel = 1'b0;
    multiplicand = 8'h00; multiplier = 8'h00;
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    chk("reset_product", product, 16'h0000);
    chk("reset_zflag", {15'd0, z_flag_multiplier}, 16'h0001);
    chk("reset_iter", {12'd0, iter_cnt}, 16'h0000);
    #7 rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 * 3 = 15
    do_load(8'd5, 8'd3);
    do_shift(2);
    chk("p5x3", product, 16'h000F);
    chk("z5x3", {15'd0, z_flag_multiplier}, 16'h0001);
    chk("i5x3", {12'd0, iter_cnt}, 16'h0002);

    // -7 * 6 = -42, and an extra shift changes nothing but the count
    do_load(8'hF9, 8'd6);
    do_shift(3);
    chk("pm7x6", product, 16'hFFD6);
    do_shift(1);
    chk("pm7x6_extra", product, 16'hFFD6);
    chk("im7x6_extra", {12'd0, iter_cnt}, 16'h0004);

    // -128 * -128 = 16384 and -128 * 127 = -16256
    do_load(8'h80, 8'h80);
    do_shift(8);
    chk("pm128xm128", product, 16'h4000);
    do_load(8'h80, 8'h7F);
    do_shift(7);
    chk("pm128x127", product, 16'hC080);

    // -9 * 0: zero flag right after load and product stays zero
    do_load(8'hF7, 8'h00);
    chk("zm9x0", {15'd0, z_flag_multiplier}, 16'h0001);
    chk("pm9x0_load", product, 16'h0000);
    do_shift(3);
    chk("pm9x0_shift", product, 16'h0000);

    // Restart mid-operation; the reload also asserts shift_en (load wins)
    do_load(8'd12, 8'd10);
    do_shift(2);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 8'd4);
    do_shift(3);
    chk("p3x4_restart", product, 16'h000C);
    chk("i3x4_restart", {12'd0, iter_cnt}, 16'h0003);

    // reg_en low: toggling inputs and strobes must not move anything
    for (int i = 0; i < 4; i++)
      cyc(1'b0, i[0], ~i[0], 1'b1, 8'($urandom), 8'($urandom));
    chk("p_hold", product, 16'h000C);
    chk("i_hold", {12'd0, iter_cnt}, 16'h0003);

    // Iteration count saturates at 15
    do_load(8'd1, 8'd1);
    do_shift(17);
    chk("i_sat", {12'd0, iter_cnt}, 16'h000F);
    chk("p_sat", product, 16'h0001);

    // psel=0 during a shift clears the accumulated product
    do_load(8'd9, 8'd3);
    do_shift(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    chk("p_psel0", product, 16'h0000);

    // Async reset between edges mid-multiplication, then a clean multiply
    do_load(8'd5, 8'd3);
    do_shift(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_product", product, 16'h0000);
    chk("arst_zflag", {15'd0, z_flag_multiplier}, 16'h0001);
    chk("arst_iter", {12'd0, iter_cnt}, 16'h0000);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_load(8'hFD, 8'd5);
    do_shift(3);
    chk("pm3x5_after_rst", product, 16'hFFF1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port load, input, 1 bit: capture new operands (control unit load strobe).
REQ-005 Port reg_en, input, 1 bit: enables any register update; when low, all registers hold.
REQ-006 Port shift_en, input, 1 bit: performs one shift-add iteration.
REQ-007 Port psel, input, 1 bit: product-register input select; 0 = zero, 1 = adder result.
REQ-008 Port multiplicand, input, 8 bits: signed two's-complement operand A (switches).
REQ-009 Port multiplier, input, 8 bits: signed two's-complement operand B (switches).
REQ-010 Port product, output, 16 bits: signed two's-complement result.
REQ-011 Port z_flag_multiplier, output, 1 bit: high when the internal multiplier register equals 0.
REQ-012 Port iter_cnt, output, 4 bits: count of shift iterations since the last load, for display and debug.

Function
REQ-013 Internal state SHALL be: mcand_reg (16 b, unsigned magnitude), mplier_reg (8 b, unsigned magnitude), prod_reg (16 b, unsigned magnitude), sign_reg (1 b), iter_cnt (4 b).
REQ-014 Load cycle (reg_en=1, load=1):
- mcand_reg <= {8'b0, |multiplicand|}
- mplier_reg <= |multiplier|
- prod_reg <= 0 (psel=0 path)
- sign_reg <= multiplicand[7] XOR multiplier[7]
- iter_cnt <= 0
REQ-015 Magnitude SHALL be computed in 8-bit unsigned, so |-128| = 128 (0x80) with no overflow.
REQ-016 load SHALL take priority over shift_en when both are high in the same cycle.
REQ-017 Shift cycle (reg_en=1, shift_en=1, load=0):
- prod_reg <= prod_reg + mcand_reg if mplier_reg[0]=1 and psel=1; prod_reg <= 0 if psel=0; prod_reg holds otherwise
- mcand_reg <= mcand_reg << 1
- mplier_reg <= mplier_reg >> 1 (logical)
- iter_cnt <= iter_cnt + 1, saturating at 15
REQ-018 The 16-bit add SHALL NOT overflow for any operand pair; the maximum magnitude is 128*128 = 16384.
REQ-019 reg_en=0, or reg_en=1 with load=0 and shift_en=0, SHALL hold all registers.
REQ-020 z_flag_multiplier SHALL be combinational: (mplier_reg == 0).
REQ-021 product SHALL be combinational: sign_reg ? (~prod_reg + 1) : prod_reg.
REQ-022 A product of magnitude 0 SHALL read 0x0000 regardless of sign_reg.
REQ-023 Latency: the final product SHALL be valid after k shift cycles, where k = (bit position of the MSB of |B|) + 1.
- k = 0 when B = 0, i.e. valid immediately after the load cycle.
- Maximum k = 8, for |B| = 128.
REQ-024 Shift cycles issued while mplier_reg = 0 SHALL leave prod_reg, and therefore product, unchanged. The control unit spends one such cycle in its compute state before it observes z_flag_multiplier.
REQ-025 Operand inputs SHALL be sampled only on load cycles; changes at any other time SHALL NOT affect state or outputs.
REQ-026 A load during an in-progress multiplication SHALL discard that multiplication and restart from the new operands.

Reset
REQ-027 While rst_n=0, the block SHALL clear all registers asynchronously, regardless of clk.
- Resulting outputs: product = 0x0000, z_flag_multiplier = 1, iter_cnt = 0.
REQ-028 After rst_n deasserts, registers SHALL update from the first rising clk edge onward.
REQ-029 Reset asserted mid-operation SHALL abort the multiplication with no residual state.

Verification
REQ-030 A=5, B=3; one load cycle, then shift cycles with psel=1 -> product=0x000F after 2 shifts, z_flag_multiplier=1 after 2 shifts, iter_cnt=2.
REQ-031 A=-7 (0xF9), B=6 -> product=0xFFD6 (-42) after 3 shifts; an extra shift cycle leaves 0xFFD6 and iter_cnt=4.
REQ-032 A=-128, B=-128 -> product=0x4000 (16384) after 8 shifts; A=-128, B=127 -> product=0xC080 (-16256) after 7 shifts.
REQ-033 A=-9, B=0 -> z_flag_multiplier=1 in the cycle after load, product=0x0000 and stays 0 across 3 shift cycles.
REQ-034 A=12, B=10; after 2 shifts, load A=3, B=4 -> product=0x000C after 3 further shifts, with no trace of the first operation.
- Toggling operand inputs while reg_en=0 -> no change on any output.
REQ-035 Reset asserted between clock edges mid-multiplication -> outputs go to reset values immediately; the next load computes correctly.
